// File: rtl/gray_seq_checker.sv
// gray_seq_checker
// Consumes a Gray-code count, converts it to binary, and checks that every
// accepted sample is either a hold or the +1 successor (mod 2^WIDTH) of the
// previous one. Reports lock status, step errors and completed wrap-arounds.
module gray_seq_checker #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             locked,
   output logic             step_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count
);

   // Good-step counter only has to reach LOCK_CNT, never beyond it.
   localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam logic [WIDTH-1:0]  BIN_MAX     = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_CNT);

   // Registered state
   logic [1:0]        state_reg,     state_next;
   logic [WIDTH-1:0]  ref_reg,       ref_next;
   logic [GOOD_W-1:0] good_reg,      good_next;
   logic [WIDTH-1:0]  bin_out_reg,   bin_out_next;
   logic              bin_valid_reg, bin_valid_next;
   logic              step_err_reg,  step_err_next;
   logic              locked_reg,    locked_next;
   logic [CNT_W-1:0]  err_cnt_reg,   err_cnt_next;
   logic [CNT_W-1:0]  wrap_cnt_reg,  wrap_cnt_next;

   // Combinational helpers
   logic [WIDTH-1:0]  sample_bin;
   logic [WIDTH-1:0]  ref_inc;
   logic [GOOD_W-1:0] good_inc;
   logic              is_hold;
   logic              is_succ;
   logic              ref_at_max;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
         assign sample_bin[gi] = ^gray_in[WIDTH-1:gi];
      end
   endgenerate

   assign ref_inc    = ref_reg + WIDTH'(1);
   assign good_inc   = good_reg + GOOD_W'(1);
   assign is_hold    = (sample_bin == ref_reg);
   assign is_succ    = (sample_bin == ref_inc);
   assign ref_at_max = (ref_reg == BIN_MAX);

   // Next-state and next-output decode for one accepted (or ignored) sample.
   always_comb begin
      state_next     = state_reg;
      ref_next       = ref_reg;
      good_next      = good_reg;
      bin_out_next   = bin_out_reg;
      bin_valid_next = 1'b0;
      step_err_next  = 1'b0;
      err_cnt_next   = err_cnt_reg;
      wrap_cnt_next  = wrap_cnt_reg;

      if (en) begin
         bin_valid_next = 1'b1;
         bin_out_next   = sample_bin;
         case (state_reg)
            ST_IDLE: begin
               // First sample after reset only establishes the reference.
               ref_next   = sample_bin;
               good_next  = '0;
               state_next = ST_ACQUIRE;
            end
            ST_ACQUIRE, ST_LOCKED: begin
               if (is_hold) begin
                  // Counter stalled: legal, but no progress toward lock.
                  state_next = state_reg;
               end else if (is_succ) begin
                  ref_next = sample_bin;
                  if (ref_at_max) begin
                     wrap_cnt_next = wrap_cnt_reg + CNT_W'(1);
                  end
                  if (state_reg == ST_ACQUIRE) begin
                     good_next = good_inc;
                     if (good_inc == LOCK_TARGET) begin
                        state_next = ST_LOCKED;
                     end
                  end
               end else begin
                  // Skip, backward step or multi-bit jump: resynchronise on it.
                  step_err_next = 1'b1;
                  if (err_cnt_reg != CNT_MAX) begin
                     err_cnt_next = err_cnt_reg + CNT_W'(1);
                  end
                  ref_next   = sample_bin;
                  good_next  = '0;
                  state_next = ST_ACQUIRE;
               end
            end
            default: begin
               state_next = ST_IDLE;
               good_next  = '0;
            end
         endcase
      end
   end

   assign locked_next = (state_next == ST_LOCKED);

   // State and output registers; reset discards all history immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         ref_reg       <= '0;
         good_reg      <= '0;
         bin_out_reg   <= '0;
         bin_valid_reg <= 1'b0;
         step_err_reg  <= 1'b0;
         locked_reg    <= 1'b0;
         err_cnt_reg   <= '0;
         wrap_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         ref_reg       <= ref_next;
         good_reg      <= good_next;
         bin_out_reg   <= bin_out_next;
         bin_valid_reg <= bin_valid_next;
         step_err_reg  <= step_err_next;
         locked_reg    <= locked_next;
         err_cnt_reg   <= err_cnt_next;
         wrap_cnt_reg  <= wrap_cnt_next;
      end
   end

   assign bin_out    = bin_out_reg;
   assign bin_valid  = bin_valid_reg;
   assign locked     = locked_reg;
   assign step_err   = step_err_reg;
   assign err_count  = err_cnt_reg;
   assign wrap_count = wrap_cnt_reg;

endmodule
